// File: rtl/counter_ctrl_if.sv
// Command channel of counter_ctrl: valid/ready handshake carrying direction and step count.
interface counter_ctrl_if #(
  parameter int STEP_W = 4
);
  // A command transfers on a rising edge where cmd_valid and cmd_ready are both high.
  // The master holds cmd_dir/cmd_steps stable while cmd_valid is high and not yet accepted.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/counter_ctrl.sv
// Step-strobe controller for an external up/down counter: IDLE -> RUN -> DONE.
// Optional saturation stop is compiled in with macro COUNTER_CTRL_SAT_EN.
module counter_ctrl #(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  counter_ctrl_if.slave     cmd,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              count_up,
  output logic              count_down,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              sat,
  output logic [STEP_W-1:0] steps_left,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              dir_q;
  logic [STEP_W-1:0] steps_q;
  logic              abort_q;
  logic              accept;
  logic              strobe;
  logic              end_abort;
  logic              end_sat;
  logic              sat_hit;

`ifdef COUNTER_CTRL_SAT_EN
  logic sat_q;

  // Stop before a strobe that would wrap the counter past its end value.
  assign sat_hit = dir_q ? (cnt_in == {WIDTH{1'b0}}) : (cnt_in == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else if (accept) begin
      sat_q <= 1'b0;
    end else if (end_sat) begin
      sat_q <= 1'b1;
    end
  end

  assign sat = done & sat_q;
`else
  // Without saturation the counter value is irrelevant; the name marks it as deliberately unused.
  logic unused_cnt_in;
  assign unused_cnt_in = ^cnt_in;
  assign sat_hit       = 1'b0;
  assign sat           = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    strobe    = 1'b0;
    end_abort = 1'b0;
    end_sat   = 1'b0;
    accept    = (state_q == IDLE) && cmd.cmd_valid;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (cmd.cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort outranks saturation; either one suppresses this cycle's strobe.
        if (abort) begin
          end_abort = 1'b1;
          state_d   = DONE;
        end else if (sat_hit) begin
          end_sat = 1'b1;
          state_d = DONE;
        end else begin
          strobe = 1'b1;
          if (steps_q == STEP_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      steps_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dir_q   <= cmd.cmd_dir;
        steps_q <= cmd.cmd_steps;
        abort_q <= 1'b0;
      end else if (strobe) begin
        steps_q <= steps_q - STEP_W'(1);
      end
      if (end_abort) begin
        abort_q <= 1'b1;
      end
    end
  end

  assign cmd.cmd_ready = (state_q == IDLE);
  assign count_up      = strobe & ~dir_q;
  assign count_down    = strobe & dir_q;
  assign busy          = (state_q == RUN) || (state_q == DONE);
  assign done          = (state_q == DONE);
  assign aborted       = done & abort_q;
  assign steps_left    = steps_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed commands, a counter model closing the cnt_in loop,
// and a monitor that scores each completed command against an expected queue.
module tb_counter_ctrl;
  localparam int WIDTH  = 3;
  localparam int STEP_W = 4;
  localparam int W      = 19;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              abort;
  logic [WIDTH-1:0]  cnt;
  logic              count_up, count_down, busy, done, aborted, sat;
  logic [STEP_W-1:0] steps_left;
  logic [1:0]        state_dbg;

  counter_ctrl_if #(.STEP_W(STEP_W)) cmd_bus ();

  counter_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_bus),
    .abort      (abort),
    .cnt_in     (cnt),
    .count_up   (count_up),
    .count_down (count_down),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .sat        (sat),
    .steps_left (steps_left),
    .state_dbg  (state_dbg)
  );

  // external counter model, with a preset hook for the driver
  logic             preset_req = 1'b0;
  logic [WIDTH-1:0] preset_val = '0;
  always @(posedge clk) begin
    if (preset_req)      cnt <= preset_val;
    else if (count_up)   cnt <= cnt + 1'b1;
    else if (count_down) cnt <= cnt - 1'b1;
  end

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {latency, aborted, sat, up pulses, down pulses, steps_left at done}
  function automatic logic [W-1:0] pack(input int lat, input bit ab, input bit st,
                                        input int ups, input int downs, input int sl);
    return {lat[4:0], ab, st, ups[3:0], downs[3:0], sl[3:0]};
  endfunction

  // monitor
  initial begin
    bit tracking;
    int lat, ups, downs;
    logic [W-1:0] got;
    tracking = 1'b0;
    lat = 0; ups = 0; downs = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        tracking = 1'b0;
      end else begin
        check("no_dual_strobe", {31'd0, count_up & count_down}, 32'd0);
        if (!done) check("flags_low_without_done", {30'd0, aborted, sat}, 32'd0);
        if (tracking) begin
          lat++;
          ups   += int'(count_up);
          downs += int'(count_down);
          if (done) begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL done_without_expectation: got done=1 expected no command pending");
            end else begin
              got = {lat[4:0], aborted, sat, ups[3:0], downs[3:0], steps_left};
              check("cmd_result", {13'd0, got}, {13'd0, exp_q.pop_front()});
              check("ready_low_in_done", {31'd0, cmd_bus.cmd_ready}, 32'd0);
              check("busy_in_done", {31'd0, busy}, 32'd1);
            end
            tracking = 1'b0;
          end
        end else if (done) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1 expected 0 (t=%0t)", $time);
        end
        if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
          tracking = 1'b1;
          lat = 0; ups = 0; downs = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic set_cnt(input logic [WIDTH-1:0] v);
    preset_val = v;
    preset_req = 1'b1;
    @(posedge clk); #1;
    preset_req = 1'b0;
  endtask

  task automatic send_cmd(input bit dir, input logic [STEP_W-1:0] steps, input bit keep,
                          output int waits);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_dir   = dir;
    cmd_bus.cmd_steps = steps;
    waits = 0;
    while (!cmd_bus.cmd_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!cmd_bus.cmd_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 50 cycles");
      cmd_bus.cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (!keep) cmd_bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_bus.cmd_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_bus.cmd_ready) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got cmd_ready=0 expected 1 within 60 cycles");
    end
  endtask

  // stimulus
  initial begin
    int w;
    int n;
    abort             = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_dir   = 1'b0;
    cmd_bus.cmd_steps = '0;
    set_cnt('0);

    // reset values
    check("rst_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
    check("rst_count_up", {31'd0, count_up}, 32'd0);
    check("rst_count_down", {31'd0, count_down}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aborted", {31'd0, aborted}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    check("rst_steps_left", {28'd0, steps_left}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // up 3 from 0
    set_cnt(3'd0);
    exp_q.push_back(pack(4, 0, 0, 3, 0, 0));
    send_cmd(1'b0, 4'd3, 1'b0, w);
    wait_idle();

    // down 0 steps, abort held through acceptance and DONE (ignored there)
    exp_q.push_back(pack(1, 0, 0, 0, 0, 0));
    abort = 1'b1;
    send_cmd(1'b1, 4'd0, 1'b0, w);
    wait_idle();
    abort = 1'b0;

    // up 5, abort in the 3rd RUN cycle
    set_cnt(3'd1);
    exp_q.push_back(pack(4, 1, 0, 2, 0, 3));
    send_cmd(1'b0, 4'd5, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle();

    // down 3 from 5
    set_cnt(3'd5);
    exp_q.push_back(pack(4, 0, 0, 0, 3, 0));
    send_cmd(1'b1, 4'd3, 1'b0, w);
    wait_idle();

    // up 4 from 6: saturates at 7 when enabled, wraps otherwise
    set_cnt(3'd6);
`ifdef COUNTER_CTRL_SAT_EN
    exp_q.push_back(pack(3, 0, 1, 1, 0, 3));
`else
    exp_q.push_back(pack(5, 0, 0, 4, 0, 0));
`endif
    send_cmd(1'b0, 4'd4, 1'b0, w);
    wait_idle();

    // down 3 from 1: saturates at 0 when enabled
    set_cnt(3'd1);
`ifdef COUNTER_CTRL_SAT_EN
    exp_q.push_back(pack(3, 0, 1, 0, 1, 2));
`else
    exp_q.push_back(pack(4, 0, 0, 0, 3, 0));
`endif
    send_cmd(1'b1, 4'd3, 1'b0, w);
    wait_idle();

    // maximum step count from 0
    set_cnt(3'd0);
`ifdef COUNTER_CTRL_SAT_EN
    exp_q.push_back(pack(9, 0, 1, 7, 0, 8));
`else
    exp_q.push_back(pack(16, 0, 0, 15, 0, 0));
`endif
    send_cmd(1'b0, 4'd15, 1'b0, w);
    wait_idle();

    // back-to-back with cmd_valid held high
    set_cnt(3'd3);
    exp_q.push_back(pack(3, 0, 0, 2, 0, 0));
    send_cmd(1'b0, 4'd2, 1'b1, w);
    exp_q.push_back(pack(3, 0, 0, 0, 2, 0));
    send_cmd(1'b1, 4'd2, 1'b0, w);
    check("b2b_accept_gap", w, 3);
    wait_idle();

    // reset mid-RUN: command discarded, no done afterwards
    set_cnt(3'd0);
    send_cmd(1'b0, 4'd6, 1'b0, w);
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    check("midrst_count_up", {31'd0, count_up}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
    check("midrst_steps_left", {28'd0, steps_left}, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
    check("post_rst_done", {31'd0, done}, 32'd0);

    // recovery after reset
    set_cnt(3'd2);
    exp_q.push_back(pack(3, 0, 0, 2, 0, 0));
    send_cmd(1'b0, 4'd2, 1'b0, w);
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3, width of the controlled counter value.
REQ-002 SHALL have parameter STEP_W, default 4, width of the step-count field.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 SHALL have port cmd_dir  input  1  direction: 0 = up, 1 = down.
REQ-008 SHALL have port cmd_steps  input  STEP_W  number of single steps to issue.
REQ-009 SHALL have port abort  input  1  terminate the running command.
REQ-010 SHALL have port cnt_in  input  WIDTH  current counter value, fed back from the counter.
REQ-011 SHALL have port count_up  output  1  increment strobe to the counter.
REQ-012 SHALL have port count_down  output  1  decrement strobe to the counter.
REQ-013 SHALL have port busy  output  1  high in RUN and DONE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port aborted  output  1  valid with done; high when the command ended by abort.
REQ-016 SHALL have port sat  output  1  valid with done; high when the command ended by saturation.
REQ-017 SHALL have port steps_left  output  STEP_W  steps remaining in the current command.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE, with state, direction and step counter held in registers.
REQ-019 SHALL assert cmd_ready only in IDLE.
REQ-020 SHALL latch cmd_dir and cmd_steps on acceptance.
- cmd_steps nonzero: go to RUN.
- cmd_steps = 0: go directly to DONE, with no strobes issued.
REQ-021 SHALL, in RUN, assert exactly one strobe per cycle, selected by the latched direction; never both strobes in the same cycle.
REQ-022 SHALL decrement steps_left on each cycle a strobe is issued, and go to DONE on the cycle steps_left reaches 0.
- Latency: acceptance at edge N gives strobes in cycles N+1 to N+steps, and done in cycle N+steps+1.
REQ-023 SHALL gate the strobes combinationally with abort: when abort is high in RUN, no strobe is issued that cycle, the FSM goes to DONE, and aborted is set.
REQ-024 SHALL ignore abort in IDLE and DONE.
REQ-025 SHALL, in DONE, assert done for exactly one cycle, with aborted and sat stable, then return to IDLE.
REQ-026 SHALL hold aborted and sat low whenever done is low.
REQ-027 SHALL, in IDLE and DONE, hold count_up and count_down low.
REQ-028 SHALL, without saturation compiled in, issue all steps regardless of cnt_in; the counter wraps modulo 2^WIDTH.

Reset
REQ-029 SHALL, while reset is low, force the FSM to IDLE, steps_left to 0, and the direction register to 0, asynchronously.
REQ-030 SHALL hold these output values while reset is low: cmd_ready=1, count_up=0, count_down=0, busy=0, done=0, aborted=0, sat=0.
REQ-031 SHALL, when reset is asserted mid-RUN, stop strobes immediately, generate no done, and discard the command.

Configuration
REQ-032 SHALL honour macro COUNTER_CTRL_SAT_EN.
- When defined, in RUN: if direction is up and cnt_in is all ones, or direction is down and cnt_in is 0, no strobe is issued, the FSM goes to DONE, and sat is set.
- Abort has priority over saturation when both apply in the same cycle.
REQ-033 SHALL, when COUNTER_CTRL_SAT_EN is not defined, tie sat to 0 and include no saturation logic.

Verification
REQ-034 SHALL cover: reset released, cmd up with steps=3, cnt_in=0 -> count_up high for exactly 3 cycles; done in the 4th cycle; cmd_ready low through DONE.
REQ-035 SHALL cover: cmd down with steps=0 -> no strobes; done one cycle after acceptance; aborted=0, sat=0.
REQ-036 SHALL cover: cmd up with steps=5, abort high in the 3rd RUN cycle -> exactly 2 count_up pulses; done with aborted=1; steps_left=3 at abort.
REQ-037 SHALL cover: COUNTER_CTRL_SAT_EN defined, WIDTH=3, cnt_in=6, cmd up with steps=4 -> 1 pulse; when cnt_in=7, no further strobes and done with sat=1. Without the macro -> 4 pulses and sat=0.
REQ-038 SHALL cover: reset asserted mid-RUN -> strobes drop the same cycle; after release, cmd_ready=1 and no done pulse.
REQ-039 SHALL cover: back-to-back commands with cmd_valid held high -> second command accepted in the IDLE cycle after done; count_up and count_down never high together in any cycle.
